// File: rtl/afu_math_pkg.sv
// Shared definitions for the streaming math AFU: opcodes, FSM states,
// context field offsets and status bit positions.
package afu_math_pkg;

  localparam logic [31:0] OP_ADD = 32'd1;
  localparam logic [31:0] OP_SUB = 32'd2;
  localparam logic [31:0] OP_MUL = 32'd3;
  localparam logic [31:0] OP_DIV = 32'd4;
  localparam logic [31:0] OP_MOD = 32'd5;

  localparam int CTX_NUM_LSB = 0;
  localparam int CTX_SRC_LSB = 32;
  localparam int CTX_DST_LSB = 64;

  localparam int STAT_INVALID_OP = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_RSP,
    ST_EXEC,
    ST_WR_REQ,
    ST_WR_RSP,
    ST_DONE
  } state_t;

  function automatic logic is_valid_op(input logic [31:0] op);
    return (op >= OP_ADD) && (op <= OP_MOD);
  endfunction

endpackage

// File: rtl/afu_math_stream_if.sv
// Cache-line read/write channel bundle between the math AFU and the memory side.
interface afu_math_stream_if #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512
);
  logic [ADDR_LMT-1:0]    rd_req_addr;
  logic [MDATA-1:0]       rd_req_mdata;
  logic                   rd_req_en;
  logic                   rd_req_almostfull;
  logic                   rd_rsp_valid;
  logic [MDATA-1:0]       rd_rsp_mdata;
  logic [CACHE_WIDTH-1:0] rd_rsp_data;
  logic [ADDR_LMT-1:0]    wr_req_addr;
  logic [MDATA-1:0]       wr_req_mdata;
  logic [CACHE_WIDTH-1:0] wr_req_data;
  logic                   wr_req_en;
  logic                   wr_req_almostfull;
  logic                   wr_rsp0_valid;
  logic                   wr_rsp1_valid;
  logic [MDATA-1:0]       wr_rsp0_mdata;
  logic [MDATA-1:0]       wr_rsp1_mdata;

  modport master (
    output rd_req_addr, rd_req_mdata, rd_req_en,
    input  rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
    output wr_req_addr, wr_req_mdata, wr_req_data, wr_req_en,
    input  wr_req_almostfull, wr_rsp0_valid, wr_rsp1_valid, wr_rsp0_mdata, wr_rsp1_mdata
  );

  modport slave (
    input  rd_req_addr, rd_req_mdata, rd_req_en,
    output rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
    input  wr_req_addr, wr_req_mdata, wr_req_data, wr_req_en,
    output wr_req_almostfull, wr_rsp0_valid, wr_rsp1_valid, wr_rsp0_mdata, wr_rsp1_mdata
  );
endinterface

// File: rtl/afu_math_alu.sv
// Combinational 32-bit unsigned ALU shared serially by all lanes.
module afu_math_alu
  import afu_math_pkg::*;
(
  input  logic [31:0] op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        div0
);

  // Division by zero saturates to all-ones and flags the lane.
  always_comb begin
    result = '0;
    div0   = 1'b0;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_MUL: result = a * b;
      OP_DIV: begin
        if (b == '0) begin
          result = '1;
          div0   = 1'b1;
        end else begin
          result = a / b;
        end
      end
      OP_MOD: begin
        if (b == '0) begin
          result = '1;
          div0   = 1'b1;
        end else begin
          result = a % b;
        end
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/afu_math_stream.sv
// Streams NUM source lines through a serial ALU, one lane per cycle, and
// writes one result line (status word + lane results) per source line.
module afu_math_stream
  import afu_math_pkg::*;
#(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int LANES       = 7
) (
  input  logic                   clk,
  input  logic                   reset_n,
  afu_math_stream_if.master      mem,
  input  logic                   start,
  output logic                   done,
  output logic [31:0]            lines_done,
  input  logic [511:0]           afu_context
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t                 state, state_nxt;
  logic [31:0]            num, idx;
  logic [ADDR_LMT-1:0]    src_base, dst_base;
  logic [LANE_W-1:0]      lane;
  int                     lane_i;
  logic [CACHE_WIDTH-1:0] rd_line, wr_line;
  logic [31:0]            alu_op, alu_a, alu_b, alu_result;
  logic                   alu_div0;
  logic [MDATA-1:0]       tag;
  logic                   rd_accept, wr_complete, last_lane, last_line;
  logic                   unused_ctx;

  assign unused_ctx = ^{afu_context[511:CTX_DST_LSB+32],
                        afu_context[CTX_SRC_LSB+31:CTX_SRC_LSB+ADDR_LMT],
                        afu_context[CTX_DST_LSB+31:CTX_DST_LSB+ADDR_LMT]};

  assign tag         = idx[MDATA-1:0];
  assign lane_i      = int'(lane);
  assign rd_accept   = mem.rd_rsp_valid && (mem.rd_rsp_mdata == tag);
  assign wr_complete = (mem.wr_rsp0_valid && (mem.wr_rsp0_mdata == tag)) ||
                       (mem.wr_rsp1_valid && (mem.wr_rsp1_mdata == tag));
  assign last_lane   = (lane == LANE_W'(LANES - 1));
  assign last_line   = ((idx + 32'd1) == num);

  assign mem.rd_req_addr  = src_base + idx[ADDR_LMT-1:0];
  assign mem.wr_req_addr  = dst_base + idx[ADDR_LMT-1:0];
  assign mem.rd_req_mdata = tag;
  assign mem.wr_req_mdata = tag;
  assign mem.wr_req_data  = wr_line;
  assign done             = (state == ST_DONE);

  assign alu_op = rd_line[31:0];
  assign alu_a  = rd_line[32*(2*lane_i+2) +: 32];
  assign alu_b  = rd_line[32*(2*lane_i+3) +: 32];

  afu_math_alu u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .div0   (alu_div0)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Request strobes only fire in a cycle the channel can take them.
  always_comb begin
    state_nxt     = state;
    mem.rd_req_en = 1'b0;
    mem.wr_req_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (afu_context[CTX_NUM_LSB +: 32] == '0) ? ST_DONE : ST_RD_REQ;
      end
      ST_RD_REQ: begin
        if (!mem.rd_req_almostfull) begin
          mem.rd_req_en = 1'b1;
          state_nxt     = ST_RD_RSP;
        end
      end
      ST_RD_RSP: if (rd_accept) state_nxt = ST_EXEC;
      ST_EXEC:   if (last_lane) state_nxt = ST_WR_REQ;
      ST_WR_REQ: begin
        if (!mem.wr_req_almostfull) begin
          mem.wr_req_en = 1'b1;
          state_nxt     = ST_WR_RSP;
        end
      end
      ST_WR_RSP: if (wr_complete) state_nxt = last_line ? ST_DONE : ST_RD_REQ;
      ST_DONE:   state_nxt = ST_DONE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Result line is cleared on accept so status and unused words start fresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num        <= '0;
      src_base   <= '0;
      dst_base   <= '0;
      idx        <= '0;
      lane       <= '0;
      rd_line    <= '0;
      wr_line    <= '0;
      lines_done <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            num        <= afu_context[CTX_NUM_LSB +: 32];
            src_base   <= afu_context[CTX_SRC_LSB +: ADDR_LMT];
            dst_base   <= afu_context[CTX_DST_LSB +: ADDR_LMT];
            idx        <= '0;
            lines_done <= '0;
          end
        end
        ST_RD_RSP: begin
          if (rd_accept) begin
            rd_line <= mem.rd_rsp_data;
            wr_line <= '0;
            lane    <= '0;
          end
        end
        ST_EXEC: begin
          wr_line[32*(lane_i+1) +: 32] <= alu_result;
          if (alu_div0) wr_line[lane_i] <= 1'b1;
          if (!is_valid_op(alu_op)) wr_line[STAT_INVALID_OP] <= 1'b1;
          lane <= lane + 1'b1;
        end
        ST_WR_RSP: begin
          if (wr_complete) begin
            lines_done <= lines_done + 32'd1;
            idx        <= idx + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_afu_math_stream.sv
// Scoreboard bench for afu_math_stream: a memory responder model serves reads,
// expected read addresses and result lines are queued at job start.
module tb_afu_math_stream;
  import afu_math_pkg::*;

  localparam int ADDR_LMT = 20;
  localparam int MDATA    = 14;
  localparam int CW       = 512;
  localparam int LANES    = 7;

  typedef struct {
    logic [ADDR_LMT-1:0] addr;
    logic [MDATA-1:0]    tag;
  } rd_exp_t;

  typedef struct {
    logic [ADDR_LMT-1:0] addr;
    logic [MDATA-1:0]    tag;
    logic [CW-1:0]       data;
  } wr_exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          done;
  logic [31:0]   lines_done;
  logic [511:0]  afu_context;

  afu_math_stream_if #(.ADDR_LMT(ADDR_LMT), .MDATA(MDATA), .CACHE_WIDTH(CW)) mem_if ();

  afu_math_stream #(.ADDR_LMT(ADDR_LMT), .MDATA(MDATA), .CACHE_WIDTH(CW), .LANES(LANES)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem         (mem_if.master),
    .start       (start),
    .done        (done),
    .lines_done  (lines_done),
    .afu_context (afu_context)
  );

  always #5 clk = ~clk;

  rd_exp_t             rd_q[$];
  wr_exp_t             wr_q[$];
  logic [CW-1:0]       src_mem [logic [ADDR_LMT-1:0]];
  int                  assert_count = 0;
  int                  fail_count   = 0;
  int                  rd_count     = 0;
  int                  wr_mode      = 0;
  logic                rd_pend      = 1'b0;
  logic                wr_pend      = 1'b0;
  logic                inject_stale = 1'b0;
  logic                stale_sent   = 1'b0;
  logic [ADDR_LMT-1:0] rd_addr_l;
  logic [MDATA-1:0]    rd_tag_l, wr_tag_l;

  task automatic checkOutput(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] make_line(input logic [31:0] op);
    logic [CW-1:0] l;
    l = '0;
    l[31:0] = op;
    return l;
  endfunction

  function automatic logic [CW-1:0] put_lane(input logic [CW-1:0] l, input int k,
                                              input logic [31:0] a, input logic [31:0] b);
    logic [CW-1:0] r;
    r = l;
    r[32*(2*k+2) +: 32] = a;
    r[32*(2*k+3) +: 32] = b;
    return r;
  endfunction

  // Reference result line built straight from the opcode table.
  function automatic logic [CW-1:0] model_line(input logic [CW-1:0] src);
    logic [CW-1:0] o;
    logic [31:0]   op, a, b, r;
    o  = '0;
    op = src[31:0];
    for (int k = 0; k < LANES; k++) begin
      a = src[32*(2*k+2) +: 32];
      b = src[32*(2*k+3) +: 32];
      case (op)
        32'd1: r = a + b;
        32'd2: r = a - b;
        32'd3: r = a * b;
        32'd4: if (b == 0) begin r = 32'hFFFF_FFFF; o[k] = 1'b1; end else r = a / b;
        32'd5: if (b == 0) begin r = 32'hFFFF_FFFF; o[k] = 1'b1; end else r = a % b;
        default: begin r = 32'd0; o[31] = 1'b1; end
      endcase
      o[32*(k+1) +: 32] = r;
    end
    return o;
  endfunction

  // Memory side: sample requests on the falling edge, answer just after the rising edge.
  always begin
    @(negedge clk);
    if (reset_n) begin
      if (mem_if.rd_req_almostfull) checkOutput("rd_en_under_af", CW'(mem_if.rd_req_en), CW'(0));
      if (mem_if.wr_req_almostfull) checkOutput("wr_en_under_af", CW'(mem_if.wr_req_en), CW'(0));
      if (mem_if.rd_req_en) begin
        rd_exp_t re;
        rd_count++;
        checkOutput("rd_expected", CW'(rd_q.size() != 0), CW'(1));
        if (rd_q.size() != 0) begin
          re = rd_q.pop_front();
          checkOutput("rd_addr", CW'(mem_if.rd_req_addr), CW'(re.addr));
          checkOutput("rd_tag", CW'(mem_if.rd_req_mdata), CW'(re.tag));
        end
        rd_pend    = 1'b1;
        stale_sent = 1'b0;
        rd_addr_l  = mem_if.rd_req_addr;
        rd_tag_l   = mem_if.rd_req_mdata;
      end
      if (mem_if.wr_req_en) begin
        wr_exp_t we;
        checkOutput("wr_expected", CW'(wr_q.size() != 0), CW'(1));
        if (wr_q.size() != 0) begin
          we = wr_q.pop_front();
          checkOutput("wr_addr", CW'(mem_if.wr_req_addr), CW'(we.addr));
          checkOutput("wr_tag", CW'(mem_if.wr_req_mdata), CW'(we.tag));
          checkOutput("wr_data", mem_if.wr_req_data, we.data);
        end
        wr_pend  = 1'b1;
        wr_tag_l = mem_if.wr_req_mdata;
      end
    end
    @(posedge clk);
    #1;
    mem_if.rd_rsp_valid  = 1'b0;
    mem_if.wr_rsp0_valid = 1'b0;
    mem_if.wr_rsp1_valid = 1'b0;
    if (rd_pend && reset_n) begin
      mem_if.rd_rsp_valid = 1'b1;
      if (inject_stale && !stale_sent) begin
        mem_if.rd_rsp_mdata = rd_tag_l ^ 14'd1;
        mem_if.rd_rsp_data  = put_lane(make_line(32'd1), 0, 32'h1111_1111, 32'h2222_2222);
        stale_sent = 1'b1;
      end else begin
        mem_if.rd_rsp_mdata = rd_tag_l;
        mem_if.rd_rsp_data  = src_mem.exists(rd_addr_l) ? src_mem[rd_addr_l] : '0;
        rd_pend = 1'b0;
      end
    end
    if (wr_pend && reset_n) begin
      mem_if.wr_rsp0_mdata = wr_tag_l;
      mem_if.wr_rsp1_mdata = wr_tag_l;
      mem_if.wr_rsp0_valid = (wr_mode != 1);
      mem_if.wr_rsp1_valid = (wr_mode != 0);
      wr_mode = (wr_mode + 1) % 3;
      wr_pend = 1'b0;
    end
  end

  task automatic doReset();
    reset_n = 1'b0;
    start   = 1'b0;
    rd_q.delete();
    wr_q.delete();
    rd_pend = 1'b0;
    wr_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] num, input logic [31:0] src, input logic [31:0] dst);
    logic [ADDR_LMT-1:0] ra, wa;
    logic [CW-1:0]       line;
    afu_context = '0;
    afu_context[31:0]  = num;
    afu_context[63:32] = src;
    afu_context[95:64] = dst;
    for (int j = 0; j < int'(num); j++) begin
      ra   = src[ADDR_LMT-1:0] + ADDR_LMT'(j);
      wa   = dst[ADDR_LMT-1:0] + ADDR_LMT'(j);
      line = src_mem.exists(ra) ? src_mem[ra] : '0;
      rd_q.push_back('{ra, MDATA'(j)});
      wr_q.push_back('{wa, MDATA'(j), model_line(line)});
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input int max_cycles, output int cycles);
    cycles = 0;
    while (!done && cycles < max_cycles) begin
      @(posedge clk);
      #1 cycles++;
    end
  endtask

  initial begin
    int            cyc, rc;
    logic [CW-1:0] line;
    logic [31:0]   ops [3];
    reset_n = 1'b0;
    start   = 1'b0;
    afu_context = '0;
    mem_if.rd_req_almostfull = 1'b0;
    mem_if.wr_req_almostfull = 1'b0;
    mem_if.rd_rsp_valid  = 1'b0;
    mem_if.rd_rsp_mdata  = '0;
    mem_if.rd_rsp_data   = '0;
    mem_if.wr_rsp0_valid = 1'b0;
    mem_if.wr_rsp1_valid = 1'b0;
    mem_if.wr_rsp0_mdata = '0;
    mem_if.wr_rsp1_mdata = '0;
    doReset();

    checkOutput("rst_done", CW'(done), CW'(0));
    checkOutput("rst_lines_done", CW'(lines_done), CW'(0));
    checkOutput("rst_rd_en", CW'(mem_if.rd_req_en), CW'(0));
    checkOutput("rst_wr_en", CW'(mem_if.wr_req_en), CW'(0));
    checkOutput("rst_wr_data", mem_if.wr_req_data, '0);

    // Single add line; expected word1 = 12, status 0.
    src_mem[20'h00100] = put_lane(make_line(32'd1), 0, 32'd5, 32'd7);
    applyStimulus(32'd1, 32'h100, 32'h200);
    waitDone(500, cyc);
    checkOutput("t1_done", CW'(done), CW'(1));
    checkOutput("t1_lines_done", CW'(lines_done), CW'(1));
    checkOutput("t1_latency", CW'(cyc), CW'(4 + LANES));
    checkOutput("t1_sb_empty", CW'(wr_q.size()), CW'(0));
    doReset();

    // Three lines sub/mul/mod with A=10 B=3 in every lane.
    ops = '{32'd2, 32'd3, 32'd5};
    for (int j = 0; j < 3; j++) begin
      line = make_line(ops[j]);
      for (int k = 0; k < LANES; k++) line = put_lane(line, k, 32'd10, 32'd3);
      src_mem[20'h00300 + 20'(j)] = line;
    end
    applyStimulus(32'd3, 32'h300, 32'h400);
    waitDone(500, cyc);
    checkOutput("t2_done", CW'(done), CW'(1));
    checkOutput("t2_lines_done", CW'(lines_done), CW'(3));
    checkOutput("t2_latency", CW'(cyc), CW'(3 * (4 + LANES)));
    checkOutput("t2_sb_empty", CW'(wr_q.size()), CW'(0));
    doReset();

    // Divide with a zero divisor in lane 0 only.
    line = put_lane(make_line(32'd4), 0, 32'd9, 32'd0);
    line = put_lane(line, 1, 32'd9, 32'd2);
    for (int k = 2; k < LANES; k++) line = put_lane(line, k, 32'd0, 32'd1);
    src_mem[20'h00500] = line;
    applyStimulus(32'd1, 32'h500, 32'h600);
    waitDone(500, cyc);
    checkOutput("t3_done", CW'(done), CW'(1));
    checkOutput("t3_sb_empty", CW'(wr_q.size()), CW'(0));
    doReset();

    // Invalid opcode followed by a valid line, with both bases wrapping.
    src_mem[20'hFFFFF] = put_lane(make_line(32'd9), 0, 32'd4, 32'd4);
    line = put_lane(make_line(32'd1), 1, 32'hFFFF_FFFF, 32'd2);
    src_mem[20'h00000] = put_lane(line, 2, 32'd100, 32'd23);
    applyStimulus(32'd2, 32'h123F_FFFF, 32'hABCF_FFFF);
    waitDone(500, cyc);
    checkOutput("t4_done", CW'(done), CW'(1));
    checkOutput("t4_lines_done", CW'(lines_done), CW'(2));
    checkOutput("t4_sb_empty", CW'(wr_q.size()), CW'(0));
    doReset();

    // Empty job: no reads, done almost immediately.
    rc = rd_count;
    applyStimulus(32'd0, 32'h100, 32'h200);
    waitDone(10, cyc);
    checkOutput("t5_done", CW'(done), CW'(1));
    checkOutput("t5_fast", CW'(cyc <= 1), CW'(1));
    checkOutput("t5_no_reads", CW'(rd_count), CW'(rc));
    checkOutput("t5_lines_done", CW'(lines_done), CW'(0));
    doReset();

    // Backpressure on both channels plus a stale read response ahead of each real one.
    for (int j = 0; j < 2; j++) begin
      line = make_line(32'd1 + 32'(2 * j));
      for (int k = 0; k < LANES; k++) line = put_lane(line, k, $urandom, $urandom_range(1, 1000));
      src_mem[20'h00700 + 20'(j)] = line;
    end
    inject_stale = 1'b1;
    mem_if.rd_req_almostfull = 1'b1;
    mem_if.wr_req_almostfull = 1'b1;
    applyStimulus(32'd2, 32'h700, 32'h900);
    repeat (20) @(posedge clk);
    #1 mem_if.rd_req_almostfull = 1'b0;
    repeat (20) @(posedge clk);
    #1 mem_if.wr_req_almostfull = 1'b0;
    waitDone(500, cyc);
    inject_stale = 1'b0;
    checkOutput("t6_done", CW'(done), CW'(1));
    checkOutput("t6_lines_done", CW'(lines_done), CW'(2));
    checkOutput("t6_sb_empty", CW'(wr_q.size()), CW'(0));
    doReset();

    // Reset while lane 1 of the first line is executing.
    src_mem[20'h00800] = put_lane(make_line(32'd1), 0, 32'd1, 32'd2);
    src_mem[20'h00801] = put_lane(make_line(32'd2), 0, 32'd8, 32'd2);
    applyStimulus(32'd2, 32'h800, 32'hA00);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("t7_rst_done", CW'(done), CW'(0));
    checkOutput("t7_rst_lines_done", CW'(lines_done), CW'(0));
    checkOutput("t7_rst_rd_en", CW'(mem_if.rd_req_en), CW'(0));
    checkOutput("t7_rst_wr_en", CW'(mem_if.wr_req_en), CW'(0));
    checkOutput("t7_rst_wr_data", mem_if.wr_req_data, '0);
    doReset();
    applyStimulus(32'd1, 32'h100, 32'h200);
    waitDone(500, cyc);
    checkOutput("t7_rerun_done", CW'(done), CW'(1));
    checkOutput("t7_rerun_lines_done", CW'(lines_done), CW'(1));
    checkOutput("t7_rerun_latency", CW'(cyc), CW'(4 + LANES));
    checkOutput("t7_sb_empty", CW'(wr_q.size()), CW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
